nonce_sched: RTL and testbench

Sequencing controller for the parallel nonce-search datapath. It issues one candidate batch at a time to `LANES` hash/compare lanes, waits the fixed pipeline latency, and samples each lane's validity flag. It then either latches the winning lane and nonce or advances to the next batch. It enforces the iteration limit, and it owns the `start`/`done`/`fail` handshake toward the host.

---
 rtl/nonce_sched_pkg.sv | 34 +++
 rtl/nonce_sched_lat_timer.sv | 28 ++
 rtl/nonce_sched.sv | 111 +++++++++++
 tb/tb_nonce_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_sched_pkg.sv
// Shared state encodings, widths and status-flag decode for the nonce-search sequencer.
package nonce_sched_pkg;

  localparam int NONCE_W = 16;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  typedef struct packed {
    logic issue;
    logic busy;
    logic done;
    logic fail;
  } flags_t;

  // Status flags are a pure function of the state they will accompany.
  function automatic flags_t decode_flags(input state_t s);
    flags_t f;
    f       = '0;
    f.issue = (s == S_ISSUE);
    f.busy  = (s == S_ISSUE) || (s == S_WAIT) || (s == S_CHECK);
    f.done  = (s == S_DONE);
    f.fail  = (s == S_FAIL);
    return f;
  endfunction

endpackage

// File: rtl/nonce_sched_lat_timer.sv
// Loadable down-counter that paces the wait for the hash pipeline; stops at zero.
module lat_timer
  import nonce_sched_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nonce_sched.sv
// Batch sequencer for the parallel nonce search: issues a seed, waits out the hash
// latency, samples lane validity, then latches a winner, advances, or gives up.
module nonce_sched
  import nonce_sched_pkg::*;
#(
  parameter int LANES        = 3,
  parameter int HASH_LATENCY = 9,
  parameter int LOOP_LIMIT   = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LANES-1:0]   lane_valid,
  output logic               issue,
  output logic [NONCE_W-1:0] nonce_base,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [1:0]         win_lane,
  output logic [NONCE_W-1:0] win_nonce,
  output logic [CNT_W-1:0]   batches
);

  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(HASH_LATENCY - 2);
  localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(LOOP_LIMIT - 1);

  state_t state;
  state_t nxt;
  flags_t flags;
  logic   timer_zero;
  logic   hit;
  logic [1:0] hit_lane;

  // ISSUE lasts one cycle, so loading there makes the counter read HASH_LATENCY-2
  // on the first WAIT cycle and lands CHECK exactly HASH_LATENCY cycles after issue.
  lat_timer #(.W(CNT_W)) wait_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state == S_ISSUE),
    .value (WAIT_LOAD),
    .zero  (timer_zero)
  );

  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_valid[i]) begin
        hit      = 1'b1;
        hit_lane = 2'(i);
      end
    end
  end

  // Dropping start aborts any busy state before the CHECK result is considered.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_ISSUE;
      S_ISSUE: nxt = start ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!start)          nxt = S_IDLE;
        else if (timer_zero) nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!start)                     nxt = S_IDLE;
        else if (hit)                   nxt = S_DONE;
        else if (batches == LAST_BATCH) nxt = S_FAIL;
        else                            nxt = S_ISSUE;
      end
      S_DONE, S_FAIL: if (!start) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      flags      <= '0;
      nonce_base <= '0;
      batches    <= '0;
      win_lane   <= '0;
      win_nonce  <= '0;
    end else begin
      state <= nxt;
      flags <= decode_flags(nxt);
      if (state == S_IDLE && nxt == S_ISSUE) begin
        nonce_base <= '0;
        batches    <= '0;
        win_lane   <= '0;
        win_nonce  <= '0;
      end
      if (state == S_CHECK && start) begin
        batches <= batches + 1'b1;
        if (nxt == S_DONE) begin
          win_lane  <= hit_lane;
          win_nonce <= nonce_base;
        end
        if (nxt == S_ISSUE) begin
          nonce_base <= nonce_base + 1'b1;
        end
      end
    end
  end

  assign issue = flags.issue;
  assign busy  = flags.busy;
  assign done  = flags.done;
  assign fail  = flags.fail;

endmodule

// File: tb/tb_nonce_sched.sv
// Scoreboard bench for nonce_sched: default instance plus a LOOP_LIMIT=4 instance.
module tb_nonce_sched;

  typedef struct {
    int kind;   // 0 issue, 1 done rise, 2 fail rise
    int rel;
    int nonce;
    int lane;
    int bat;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [2:0]  lv_a = '0, lv_b = '0;
  logic        issue_a, busy_a, done_a, fail_a;
  logic        issue_b, busy_b, done_b, fail_b;
  logic [15:0] nonce_a, win_nonce_a, batches_a;
  logic [15:0] nonce_b, win_nonce_b, batches_b;
  logic [1:0]  win_lane_a, win_lane_b;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int base = 0;
  ev_t q_a[$];
  ev_t q_b[$];
  logic done_a_q = 1'b0, fail_a_q = 1'b0, done_b_q = 1'b0, fail_b_q = 1'b0;

  nonce_sched dut_a (
    .clk(clk), .reset(reset), .start(start_a), .lane_valid(lv_a),
    .issue(issue_a), .nonce_base(nonce_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .win_lane(win_lane_a), .win_nonce(win_nonce_a), .batches(batches_a)
  );

  nonce_sched #(.LOOP_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .lane_valid(lv_b),
    .issue(issue_b), .nonce_base(nonce_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .win_lane(win_lane_b), .win_nonce(win_nonce_b), .batches(batches_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", nm, act, exp, ecount - base);
    end
  endtask

  task automatic push_ev(input int which, input int kind, input int rel,
                         input int nonce, input int lane, input int bat);
    ev_t e;
    e = '{kind, rel, nonce, lane, bat};
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
  endtask

  task automatic observe(input int which, input int kind, input int nonce,
                         input int lane, input int bat);
    ev_t e;
    if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got kind %0d at rel %0d, expected none",
               which, kind, ecount - base);
    end else begin
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      cmp("event_kind", kind, e.kind);
      cmp("event_cycle", ecount - base, e.rel);
      cmp("event_nonce", nonce, e.nonce);
      cmp("event_lane", lane, e.lane);
      cmp("event_batches", bat, e.bat);
    end
  endtask

  // Monitor: reacts to issue pulses and done/fail rising edges of each instance.
  always @(negedge clk) begin
    if (issue_a) observe(0, 0, int'(nonce_a), int'(win_lane_a), int'(batches_a));
    if (done_a && !done_a_q) observe(0, 1, int'(win_nonce_a), int'(win_lane_a), int'(batches_a));
    if (fail_a && !fail_a_q) observe(0, 2, int'(nonce_a), int'(win_lane_a), int'(batches_a));
    if (issue_b) observe(1, 0, int'(nonce_b), int'(win_lane_b), int'(batches_b));
    if (done_b && !done_b_q) observe(1, 1, int'(win_nonce_b), int'(win_lane_b), int'(batches_b));
    if (fail_b && !fail_b_q) observe(1, 2, int'(nonce_b), int'(win_lane_b), int'(batches_b));
    done_a_q <= done_a;
    fail_a_q <= fail_a;
    done_b_q <= done_b;
    fail_b_q <= fail_b;
  end

  task automatic wait_rel(input int r);
    while (ecount - base < r) @(negedge clk);
  endtask

  task automatic begin_search_a();
    base = ecount;
    start_a = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp("reset_issue", int'(issue_a), 0);
    cmp("reset_busy", int'(busy_a), 0);
    cmp("reset_done", int'(done_a), 0);
    cmp("reset_fail", int'(fail_a), 0);
    cmp("reset_nonce", int'(nonce_a), 0);
    cmp("reset_batches", int'(batches_a), 0);
    cmp("reset_busy_b", int'(busy_b), 0);
    reset = 1'b0;
    @(negedge clk);

    // Hit on lane 1 in batch 0.
    begin_search_a();
    push_ev(0, 0, 1, 0, 0, 0);
    push_ev(0, 1, 11, 0, 1, 1);
    wait_rel(1);
    cmp("busy_in_issue", int'(busy_a), 1);
    wait_rel(10);
    lv_a = 3'b010;
    wait_rel(11);
    lv_a = 3'b000;
    cmp("done_at_11", int'(done_a), 1);

    // Outputs hold while start stays high, then done clears after one low edge.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmp("hold_done", int'(done_a), 1);
      cmp("hold_lane", int'(win_lane_a), 1);
      cmp("hold_nonce", int'(win_nonce_a), 0);
      cmp("hold_batches", int'(batches_a), 1);
      cmp("hold_busy", int'(busy_a), 0);
    end
    start_a = 1'b0;
    @(negedge clk);
    cmp("idle_done", int'(done_a), 0);
    cmp("idle_busy", int'(busy_a), 0);
    cmp("idle_keep_lane", int'(win_lane_a), 1);
    cmp("idle_keep_batches", int'(batches_a), 1);

    // Restart; hit on lanes 0 and 2 in batch 3, lowest index wins.
    begin_search_a();
    for (int n = 0; n < 4; n++) push_ev(0, 0, 1 + 10 * n, n, 0, n);
    push_ev(0, 1, 41, 3, 0, 4);
    wait_rel(40);
    lv_a = 3'b101;
    wait_rel(41);
    lv_a = 3'b000;
    cmp("done_at_41", int'(done_a), 1);
    start_a = 1'b0;
    @(negedge clk);
    cmp("idle2_done", int'(done_a), 0);

    // Valid flags only during WAIT are ignored; abort in WAIT of batch 2.
    begin_search_a();
    for (int n = 0; n < 3; n++) push_ev(0, 0, 1 + 10 * n, n, 0, n);
    for (int r = 2; r <= 25; r++) begin
      wait_rel(r);
      lv_a = (r % 10 >= 2) ? 3'b111 : 3'b000;
    end
    start_a = 1'b0;
    wait_rel(26);
    lv_a = 3'b000;
    cmp("abort_busy", int'(busy_a), 0);
    cmp("abort_done", int'(done_a), 0);
    cmp("abort_issue", int'(issue_a), 0);
    cmp("abort_batches", int'(batches_a), 2);
    cmp("abort_nonce", int'(nonce_a), 2);
    repeat (30) @(negedge clk);

    // Reset during CHECK of batch 5 while lanes report a hit.
    begin_search_a();
    for (int n = 0; n < 6; n++) push_ev(0, 0, 1 + 10 * n, n, 0, n);
    wait_rel(60);
    cmp("pre_reset_busy", int'(busy_a), 1);
    cmp("pre_reset_nonce", int'(nonce_a), 5);
    lv_a = 3'b111;
    reset = 1'b1;
    wait_rel(61);
    cmp("rst_issue", int'(issue_a), 0);
    cmp("rst_busy", int'(busy_a), 0);
    cmp("rst_done", int'(done_a), 0);
    cmp("rst_fail", int'(fail_a), 0);
    cmp("rst_nonce", int'(nonce_a), 0);
    cmp("rst_batches", int'(batches_a), 0);
    cmp("rst_win_lane", int'(win_lane_a), 0);
    cmp("rst_win_nonce", int'(win_nonce_a), 0);
    reset = 1'b0;
    start_a = 1'b0;
    lv_a = 3'b000;
    repeat (5) @(negedge clk);

    // LOOP_LIMIT=4 instance never sees a valid lane.
    base = ecount;
    start_b = 1'b1;
    for (int n = 0; n < 4; n++) push_ev(1, 0, 1 + 10 * n, n, 0, n);
    push_ev(1, 2, 41, 3, 0, 4);
    wait_rel(41);
    cmp("fail_at_41", int'(fail_b), 1);
    cmp("fail_no_done", int'(done_b), 0);
    cmp("fail_batches", int'(batches_b), 4);
    repeat (5) @(negedge clk);
    cmp("fail_held", int'(fail_b), 1);
    start_b = 1'b0;
    @(negedge clk);
    cmp("fail_cleared", int'(fail_b), 0);

    repeat (3) @(negedge clk);
    cmp("pending_events_a", q_a.size(), 0);
    cmp("pending_events_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
